// File: rtl/lutram_test_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lutram_test_pkg: states, pattern modes and pattern generator for   |
// | the dual-port LUTRAM self-test.              Revision: 1.0         |
// +--------------------------------------------------------------------+
package lutram_test_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_CHECKER = 2'd0;
  localparam logic [1:0] MODE_ADDR    = 2'd1;
  localparam logic [1:0] MODE_NADDR   = 2'd2;
  localparam logic [1:0] MODE_WALK    = 2'd3;

  localparam int PAT_MAX_W = 16;

  // Full 16-bit pattern; callers truncate to their data width.
  function automatic logic [PAT_MAX_W-1:0] pat(input logic [1:0]  mode,
                                               input logic [31:0] x,
                                               input logic [31:0] dw);
    logic [PAT_MAX_W-1:0] r;
    logic [31:0]          idx;
    r   = '0;
    idx = x % dw;
    case (mode)
      MODE_CHECKER: for (int i = 0; i < PAT_MAX_W; i++) r[i] = x[0] ^ i[0];
      MODE_ADDR:    r = x[PAT_MAX_W-1:0];
      MODE_NADDR:   r = ~x[PAT_MAX_W-1:0];
      default:      r[idx[3:0]] = 1'b1;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_lutram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dp_lutram: DEPTH x D_WIDTH distributed RAM, one synchronous write  |
// | port and two asynchronous reads (SPO/DPO).   Revision: 1.0         |
// +--------------------------------------------------------------------+
module dp_lutram #(
  parameter int A_WIDTH = 6,
  parameter int D_WIDTH = 1
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] a_i,
  input  logic [D_WIDTH-1:0] d_i,
  input  logic [A_WIDTH-1:0] dpra_i,
  output logic [D_WIDTH-1:0] spo_o,
  output logic [D_WIDTH-1:0] dpo_o
);

  localparam int DEPTH = 2**A_WIDTH;

  // Kept so the RAM under test is never optimised away or moved into block RAM.
  (* ram_style = "distributed", keep = "true" *)
  logic [D_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[a_i] <= d_i;
  end

  assign spo_o = mem_q[a_i];
  assign dpo_o = mem_q[dpra_i];

endmodule
`default_nettype wire

// File: rtl/lutram_dp_selftest.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lutram_dp_selftest: clear / pattern-write / dual-port readback     |
// | sweep of a distributed RAM with error reporting.  Revision: 1.0    |
// +--------------------------------------------------------------------+
module lutram_dp_selftest #(
  parameter int A_WIDTH   = 6,
  parameter int D_WIDTH   = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_i,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic                 inject_i,
  input  logic [A_WIDTH-1:0]   inject_addr_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [CNT_WIDTH-1:0] err_count_o,
  output logic [A_WIDTH-1:0]   first_err_addr_o,
  output logic [D_WIDTH-1:0]   spo_o,
  output logic [D_WIDTH-1:0]   dpo_o
);

  import lutram_test_pkg::*;

  localparam logic [A_WIDTH-1:0]   A_ONE   = A_WIDTH'(1);
  localparam logic [A_WIDTH-1:0]   A_LAST  = '1;
  localparam logic [CNT_WIDTH+1:0] CNT_MAX = {2'b00, {CNT_WIDTH{1'b1}}};

  state_t                 state_q;
  logic [A_WIDTH-1:0]     a_q;
  logic                   start_pend_q;
  logic [1:0]             mode_q;
  logic                   inject_q;
  logic [CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
  logic [A_WIDTH-1:0]     first_err_q, first_err_d;
  logic                   err_seen_q, err_seen_d;
  logic                   busy_q, done_q, pass_q;

  logic [A_WIDTH-1:0]     w_b;
  logic [D_WIDTH-1:0]     w_pat_a, w_pat_b, w_wdata, w_spo, w_dpo;
  logic                   w_we, w_inj_hit, w_mis_s, w_mis_d;
  logic [CNT_WIDTH+1:0]   w_sum;

  assign w_b       = a_q + A_ONE;
  assign w_pat_a   = D_WIDTH'(pat(mode_q, 32'(a_q), 32'(D_WIDTH)));
  assign w_pat_b   = D_WIDTH'(pat(mode_q, 32'(w_b), 32'(D_WIDTH)));
  assign w_inj_hit = inject_q && (a_q == inject_addr_i);
  assign w_wdata   = (state_q == CLEAR) ? '0 : (w_pat_a ^ D_WIDTH'(w_inj_hit));
  assign w_we      = tick_i && ((state_q == CLEAR) || (state_q == WRITE));

  dp_lutram #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we_i   (w_we),
    .a_i    (a_q),
    .d_i    (w_wdata),
    .dpra_i (w_b),
    .spo_o  (w_spo),
    .dpo_o  (w_dpo)
  );

  assign w_mis_s = (w_spo != w_pat_a);
  assign w_mis_d = (w_dpo != w_pat_b);

  // Two-bit sum of the port mismatches is {and, xor}; widen by two so the
  // saturation check sees any overflow past all-ones.
  always_comb begin
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    err_seen_d  = err_seen_q;
    w_sum       = {2'b00, err_cnt_q} + (CNT_WIDTH+2)'({w_mis_s & w_mis_d, w_mis_s ^ w_mis_d});
    err_cnt_d   = (w_sum > CNT_MAX) ? '1 : w_sum[CNT_WIDTH-1:0];
    if (!err_seen_q && (w_mis_s || w_mis_d)) begin
      err_seen_d  = 1'b1;
      first_err_d = w_mis_s ? a_q : w_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      start_pend_q <= 1'b0;
      mode_q       <= MODE_CHECKER;
      inject_q     <= 1'b0;
      err_cnt_q    <= '0;
      first_err_q  <= '0;
      err_seen_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      if (((state_q == IDLE) || (state_q == DONE)) && start_i) start_pend_q <= 1'b1;
      if (tick_i) begin
        case (state_q)
          IDLE, DONE: begin
            if (start_pend_q) begin
              state_q      <= CLEAR;
              a_q          <= '0;
              start_pend_q <= 1'b0;
              err_cnt_q    <= '0;
              first_err_q  <= '0;
              err_seen_q   <= 1'b0;
              mode_q       <= mode_i;
              inject_q     <= inject_i;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
              pass_q       <= 1'b0;
            end
          end
          CLEAR: begin
            a_q <= a_q + A_ONE;
            if (a_q == A_LAST) state_q <= WRITE;
          end
          WRITE: begin
            a_q <= a_q + A_ONE;
            if (a_q == A_LAST) state_q <= READ;
          end
          READ: begin
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_seen_q  <= err_seen_d;
            a_q         <= a_q + A_ONE;
            if (a_q == A_LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == '0);
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign spo_o            = w_spo;
  assign dpo_o            = w_dpo;

endmodule
`default_nettype wire

// File: tb/tb_lutram_dp_selftest.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lutram_dp_selftest: directed bench for lutram_dp_selftest       |
// | (8-bit and 1-bit error counters side by side).  Revision: 1.0      |
// +--------------------------------------------------------------------+
module tb_lutram_dp_selftest;

  logic       clk, rst, tick, start, inject;
  logic [1:0] mode;
  logic [5:0] inject_addr;

  logic       busy, done, pass;
  logic [7:0] err;
  logic [5:0] fea;
  logic [3:0] spo, dpo;

  logic       busy1, done1, pass1;
  logic [0:0] err1;
  logic [5:0] fea1;
  logic [3:0] spo1, dpo1;

  int checks = 0;
  int errors = 0;
  int phase  = 0;
  logic quarter = 1'b0;
  logic hold    = 1'b0;

  lutram_dp_selftest #(.A_WIDTH(6), .D_WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .tick_i(tick), .start_i(start), .mode_i(mode),
    .inject_i(inject), .inject_addr_i(inject_addr), .busy_o(busy), .done_o(done),
    .pass_o(pass), .err_count_o(err), .first_err_addr_o(fea), .spo_o(spo), .dpo_o(dpo)
  );

  lutram_dp_selftest #(.A_WIDTH(6), .D_WIDTH(4), .CNT_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .tick_i(tick), .start_i(start), .mode_i(mode),
    .inject_i(inject), .inject_addr_i(inject_addr), .busy_o(busy1), .done_o(done1),
    .pass_o(pass1), .err_count_o(err1), .first_err_addr_o(fea1), .spo_o(spo1), .dpo_o(dpo1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Set tick for the coming edge, take the edge, settle 1 time unit after it.
  task automatic step();
    tick  = hold ? 1'b0 : (quarter ? (phase == 0) : 1'b1);
    phase = (phase + 1) % 4;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic keep_start, output int k);
    start = 1'b1;
    step();
    if (!keep_start) start = 1'b0;
    chk("busy_before_accept", busy, 0);
    k = 0;
    while (!busy && k < 8) begin
      step();
      k++;
    end
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 5000) begin
      step();
      n++;
    end
  endtask

  int k, n, n2;

  initial begin
    rst = 1'b1; start = 1'b0; tick = 1'b1; mode = 2'd0; inject = 1'b0; inject_addr = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_err",  err,  0);
    chk("reset_fea",  fea,  0);

    // Checkerboard, clean.
    mode = 2'd0; inject = 1'b0;
    launch(1'b0, k);
    chk("m0_busy_delay", k, 1);
    wait_done(n);
    chk("m0_latency", n, 192);
    chk("m0_pass", pass, 1);
    chk("m0_err", err, 0);
    chk("m0_busy_low", busy, 0);

    // Address pattern, fault at 10: DPO fails at a=9, SPO at a=10.
    mode = 2'd1; inject = 1'b1; inject_addr = 6'd10;
    launch(1'b0, k);
    wait_done(n);
    chk("m1_latency", n, 192);
    chk("m1_err", err, 2);
    chk("m1_fea", fea, 10);
    chk("m1_pass", pass, 0);

    // Walking one, fault at 0: SPO at a=0 first, DPO wraps at a=63.
    mode = 2'd3; inject = 1'b1; inject_addr = 6'd0;
    launch(1'b0, k);
    wait_done(n);
    chk("m3_err", err, 2);
    chk("m3_fea", fea, 0);
    chk("m3_pass", pass, 0);

    // Inverted address, one tick in four.
    mode = 2'd2; inject = 1'b0; quarter = 1'b1; phase = 1;
    launch(1'b0, k);
    wait_done(n);
    chk("q_latency", n, 768);
    chk("q_pass", pass, 1);
    quarter = 1'b0;

    // Stall mid-READ after 150 ticks: a=22, so SPO=~6=9 and DPO=~7=8.
    mode = 2'd2; inject = 1'b0;
    launch(1'b0, k);
    repeat (150) step();
    hold = 1'b1;
    repeat (12) step();
    chk("hold_spo", spo, 4'h9);
    chk("hold_dpo", dpo, 4'h8);
    chk("hold_spo_cnt1", spo1, 4'h9);
    chk("hold_busy", busy, 1);
    chk("hold_done", done, 0);
    chk("hold_err", err, 0);
    hold = 1'b0;
    wait_done(n2);
    chk("hold_remaining", n2, 42);
    chk("hold_pass", pass, 1);

    // Reset during WRITE at a=30, then a fresh clean run.
    mode = 2'd0; inject = 1'b0;
    launch(1'b0, k);
    repeat (94) step();
    rst = 1'b1;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    step();
    launch(1'b0, k);
    chk("rst_rerun_delay", k, 1);
    wait_done(n);
    chk("rst_rerun_latency", n, 192);
    chk("rst_rerun_pass", pass, 1);

    // Saturation on the 1-bit counter; start held while busy.
    mode = 2'd1; inject = 1'b1; inject_addr = 6'd5;
    launch(1'b1, k);
    repeat (100) step();
    start = 1'b0;
    wait_done(n);
    chk("sat_latency", n, 92);
    chk("sat_err8", err, 2);
    chk("sat_err1", err1, 1);
    chk("sat_fea1", fea1, 5);
    chk("sat_pass1", pass1, 0);
    chk("sat_done1", done1, 1);
    repeat (6) step();
    chk("norestart_done", done, 1);
    chk("norestart_busy", busy1, 0);
    chk("norestart_err1", err1, 1);
    chk("norestart_dpo1", dpo1, dpo);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lutram_dp_selftest.md
Name: lutram_dp_selftest

Overview:
- Parametrised, self-checking successor to the single-bit dual-port LUTRAM primitive test.
- Sweeps a DEPTH x D_WIDTH dual-port distributed RAM through three phases: clear, pattern write, dual-port readback. Readback compares both read ports against the expected pattern.
- Reports pass/fail, a saturating error count and the first failing address.
- Sits behind the board-level clock/reset wrapper. It advances on a clock-enable tick, not a divided clock.

Parameters:
- A_WIDTH, 6, address width; DEPTH = 2**A_WIDTH.
- D_WIDTH, 4, RAM data width (1..16).
- CNT_WIDTH, 8, error counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset; clock clk.
- tick_i  in  1  clock enable. FSM, address counter and RAM writes act only on clk edges with tick_i=1.
- start_i  in  1  start request; level, sampled every clk.
- mode_i  in  2  pattern select; latched when IDLE is left.
- inject_i  in  1  fault injection enable; latched with mode_i.
- inject_addr_i  in  A_WIDTH  address whose written data has bit 0 inverted.
- busy_o  out  1  high in CLEAR/WRITE/READ.
- done_o  out  1  high in DONE.
- pass_o  out  1  done_o and err_count_o==0.
- err_count_o  out  CNT_WIDTH  mismatch count; saturates at all-ones.
- first_err_addr_o  out  A_WIDTH  RAM address of first mismatch.
- spo_o  out  D_WIDTH  raw write-port read data.
- dpo_o  out  D_WIDTH  raw read-port data.

Behaviour:
- Reset values:
  - state IDLE, address counter a=0, start_pend=0.
  - busy_o=0, done_o=0, pass_o=0, err_count_o=0, first_err_addr_o=0, err_seen=0.
  - RAM contents are not reset.
- start_pend sets on any clk with start_i=1 in IDLE or DONE. It clears when the FSM leaves IDLE/DONE.
- IDLE/DONE -> CLEAR on a tick with start_pend=1. On that transition:
  - a=0;
  - err_count, first_err_addr and err_seen are cleared;
  - mode_i and inject_i are latched.
- start_i while busy is ignored and not queued.
- CLEAR: write 0 to address a on each tick. At a==DEPTH-1 go to WRITE with a=0.
- WRITE: write pat(a) on each tick. If inject is latched and a==inject_addr_i, write pat(a)^1 instead. At a==DEPTH-1 go to READ with a=0.
- READ:
  - SPO read address = a; DPO read address = b = (a+1) mod DEPTH. Wrap: at a=DEPTH-1, b=0.
  - On each tick, registered compare of SPO vs pat(a) and DPO vs pat(b).
  - Each mismatching port adds 1 to err_count. Both ports mismatching in the same tick adds 2. The counter saturates at all-ones.
  - first_err_addr captures on the first mismatch only (err_seen). If both ports fail on that tick, SPO (address a) wins; otherwise it captures the failing port's address.
  - At a==DEPTH-1, the final compare and the transition to DONE happen on the same edge.
- DONE holds outputs until the next start.
- Latency: DONE is entered exactly 3*DEPTH ticks after the tick that leaves IDLE.
- Patterns pat(x), x = address:
  - mode 0: checkerboard; bit i = x[0]^(i&1).
  - mode 1: x zero-extended or truncated to D_WIDTH.
  - mode 2: bitwise inverse of mode 1.
  - mode 3: walking one; bit (x mod D_WIDTH) set.
- RAM: write enable = tick in CLEAR/WRITE. Write is synchronous on clk. Both reads are asynchronous.
- rst mid-run: return to IDLE with reset output values. The next run starts from CLEAR.
- tick_i=0: all state, counters and outputs hold. spo_o/dpo_o follow the addresses combinationally.

Decomposition:
- Package lutram_test_pkg holds:
  - state encoding constants IDLE, CLEAR, WRITE, READ, DONE;
  - mode constants MODE_CHECKER, MODE_ADDR, MODE_NADDR, MODE_WALK;
  - the pat() function.
- One sub-module, dp_lutram, holds the DEPTH x D_WIDTH RAM: one sync write port, async SPO/DPO reads. It maps to RAM64X1D-class primitives and carries a keep attribute.

Test Plan (A_WIDTH=6, D_WIDTH=4, tick_i=1 every clk unless stated):
- mode 0, no inject, start pulse:
  - busy_o rises 1 clk after start;
  - done_o rises exactly 192 ticks later;
  - pass_o=1, err_count_o=0.
- mode 1, inject_i=1, inject_addr_i=10:
  - err_count_o=2: DPO at a=9, SPO at a=10;
  - first_err_addr_o=10;
  - pass_o=0.
- mode 3, inject_i=1, inject_addr_i=0 (wrap check):
  - DPO mismatch at a=63 (b=0) and SPO mismatch at a=0;
  - err_count_o=2, first_err_addr_o=0.
- tick_i high 1 clk in 4, mode 2: done_o after 4*192 clk; pass_o=1. With tick_i held low mid-READ, state, a and err_count do not change.
- rst asserted at a=30 in WRITE:
  - next clk busy_o=0, err_count_o=0;
  - a fresh mode 0 run passes.
- CNT_WIDTH=1, inject at address 5: err_count_o saturates at 1 and does not wrap; start_i held during busy causes no restart.
